// File: rtl/udp_rx_parser.sv
// udp_rx_parser: GMII receive parser that validates Ethernet/IPv4/UDP headers and packs UDP payload into RAM words.
module udp_rx_parser #(
    parameter logic [47:0] LOCAL_MAC  = 48'h000A35010203,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
    parameter logic [15:0] LOCAL_PORT = 16'd8080,
    parameter int          ADDR_W     = 9
) (
    input  logic              e_rxc,
    input  logic              reset_n,
    input  logic              gmii_rxdv,
    input  logic              gmii_rxer,
    input  logic [7:0]        gmii_rxd,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [15:0]       rx_total_length,
    output logic [15:0]       rx_data_length,
    output logic              frame_done,
    output logic              frame_drop,
    output logic [3:0]        rx_state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, PREAMBLE = 4'd1, ETH_HDR = 4'd2, IP_HDR = 4'd3, UDP_HDR = 4'd4,
        PAYLOAD = 4'd5, COMMIT = 4'd6, DROP = 4'd7, WAIT_END = 4'd8
    } state_t;
    state_t state, nxt;
    logic [39:0] sh;
    logic [15:0] cnt, tot_len, udp_len, plen, w16;
    logic [31:0] w32;
    logic [47:0] w48;
    logic hold, full, byte_v, done, we_full, we_part;
    assign byte_v   = gmii_rxdv && !gmii_rxer;
    assign w16      = {sh[7:0], gmii_rxd};
    assign w32      = {sh[23:0], gmii_rxd};
    assign w48      = {sh, gmii_rxd};
    assign plen     = udp_len - 16'd8;
    assign done     = cnt == plen;
    assign we_full  = state == PAYLOAD && !done && byte_v && cnt[1:0] == 2'd3;
    assign we_part  = state == PAYLOAD && done;
    assign rx_state = state;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = (!hold && gmii_rxdv && gmii_rxd == 8'h55) ? PREAMBLE : IDLE;
            PREAMBLE: nxt = !byte_v ? DROP :
                            gmii_rxd == 8'h55 ? (cnt == 16'd6 ? DROP : PREAMBLE) :
                            (gmii_rxd == 8'hD5 && cnt >= 16'd5) ? ETH_HDR : DROP;
            ETH_HDR:  nxt = (!byte_v || (cnt == 16'd5 && w48 != LOCAL_MAC && w48 != '1) ||
                             (cnt == 16'd13 && w16 != 16'h0800)) ? DROP :
                            cnt == 16'd13 ? IP_HDR : ETH_HDR;
            IP_HDR:   nxt = (!byte_v || (cnt == 16'd0 && gmii_rxd != 8'h45) ||
                             (cnt == 16'd9 && gmii_rxd != 8'h11) ||
                             (cnt == 16'd19 && w32 != LOCAL_IP)) ? DROP :
                            cnt == 16'd19 ? UDP_HDR : IP_HDR;
            UDP_HDR:  nxt = (!byte_v || (cnt == 16'd3 && w16 != LOCAL_PORT) ||
                             (cnt == 16'd5 && (w16 < 16'd8 || {1'b0, w16} + 17'd20 > {1'b0, tot_len}))) ? DROP :
                            cnt == 16'd7 ? (udp_len == 16'd8 ? COMMIT : PAYLOAD) : UDP_HDR;
            // an unaligned tail spends one extra PAYLOAD cycle (cnt == plen) flushing the padded word
            PAYLOAD:  nxt = done ? COMMIT : !byte_v ? DROP :
                            (cnt + 16'd1 == plen && plen[1:0] == 2'd0) ? COMMIT : PAYLOAD;
            COMMIT:   nxt = WAIT_END;
            DROP:     nxt = WAIT_END;
            WAIT_END: nxt = gmii_rxdv ? WAIT_END : IDLE;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge e_rxc) begin
        if (!reset_n) begin
            state           <= IDLE;
            hold            <= 1'b1;
            full            <= 1'b0;
            cnt             <= '0;
            sh              <= '0;
            tot_len         <= '0;
            udp_len         <= '0;
            ram_we          <= 1'b0;
            ram_addr        <= ADDR_W'(1);
            ram_wdata       <= '0;
            rx_total_length <= 16'd48;
            rx_data_length  <= 16'd28;
            frame_done      <= 1'b0;
            frame_drop      <= 1'b0;
        end else begin
            state <= nxt;
            hold  <= hold && gmii_rxdv;
            cnt   <= (nxt != state) ? '0 : cnt + 16'd1;
            sh    <= {sh[31:0], gmii_rxd};
            if (state == IP_HDR && cnt == 16'd3)
                tot_len <= w16;
            if (state == UDP_HDR && cnt == 16'd5)
                udp_len <= w16;
            ram_we <= (we_full || we_part) && !full;
            if (we_full)
                ram_wdata <= w32;
            else if (we_part)
                ram_wdata <= sh[31:0] << (6'd32 - {1'b0, plen[1:0], 3'b000});
            // once the top address has been written, later words of the frame are discarded
            if (state == WAIT_END && !gmii_rxdv) begin
                ram_addr <= ADDR_W'(1);
                full     <= 1'b0;
            end else if (ram_we) begin
                if (&ram_addr)
                    full <= 1'b1;
                else
                    ram_addr <= ram_addr + ADDR_W'(1);
            end
            frame_done <= state == COMMIT;
            frame_drop <= state == DROP;
            if (state == COMMIT) begin
                rx_total_length <= tot_len;
                rx_data_length  <= udp_len;
            end
        end
    end
endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser: directed and randomized frames checked against a byte-level reference model.
module tb_udp_rx_parser;
    localparam logic [47:0] MAC  = 48'h000A35010203;
    localparam logic [31:0] IP   = 32'hC0A80002;
    localparam logic [15:0] PORT = 16'd8080;
    localparam int          AW   = 9;
    logic          e_rxc = 1'b0, reset_n = 1'b0, gmii_rxdv = 1'b0, gmii_rxer = 1'b0;
    logic [7:0]    gmii_rxd = 8'h00;
    logic          ram_we, frame_done, frame_drop;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [15:0]   rx_total_length, rx_data_length;
    logic [3:0]    rx_state, st_after_rst;
    int            cyc = 0, checks = 0, errors = 0, n_done = 0, n_drop = 0, done_cyc = 0, last_cyc = 0, pay_start = 0;
    logic [40:0]   wq[$];
    logic [7:0]    frm[$], pl[$];
    logic [15:0]   exp_tot = 16'd48, exp_udp = 16'd28;

    udp_rx_parser dut (
        .e_rxc(e_rxc), .reset_n(reset_n), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
        .gmii_rxd(gmii_rxd), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .rx_total_length(rx_total_length), .rx_data_length(rx_data_length),
        .frame_done(frame_done), .frame_drop(frame_drop), .rx_state(rx_state)
    );

    always #4 e_rxc = ~e_rxc;
    always @(posedge e_rxc) cyc <= cyc + 1;

    always @(negedge e_rxc) begin
        if (ram_we) wq.push_back({ram_addr, ram_wdata});
        if (frame_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (frame_drop) n_drop++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic make_pl(input int n);
        pl.delete();
        repeat (n) pl.push_back(8'($urandom));
    endtask

    task automatic build(input logic [47:0] dmac, input logic [15:0] etype, input logic [7:0] vihl,
                         input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] dport,
                         input logic [15:0] ulen, input logic [15:0] tlen, input int npre);
        frm.delete();
        repeat (npre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(dmac[8*i +: 8]);
        repeat (6) frm.push_back(8'($urandom));
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(vihl); frm.push_back(8'h00); frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
        repeat (2) frm.push_back(8'($urandom));
        frm.push_back(8'h40); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(proto);
        repeat (2) frm.push_back(8'($urandom));
        frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h0A);
        for (int i = 3; i >= 0; i--) frm.push_back(dip[8*i +: 8]);
        repeat (2) frm.push_back(8'($urandom));
        frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        repeat (2) frm.push_back(8'($urandom));
        pay_start = frm.size();
        foreach (pl[i]) frm.push_back(pl[i]);
        while (frm.size() < npre + 61) frm.push_back(8'h00);
        repeat (4) frm.push_back(8'($urandom));
    endtask

    task automatic send(input int nbytes, input int err_idx, input int rst_idx, input int last_idx);
        for (int i = 0; i < nbytes; i++) begin
            @(negedge e_rxc);
            if (rst_idx >= 0 && i == rst_idx + 1) begin
                reset_n = 1'b1;
                st_after_rst = rx_state;
            end
            gmii_rxdv = 1'b1;
            gmii_rxd  = frm[i];
            gmii_rxer = (i == err_idx);
            if (i == rst_idx) reset_n = 1'b0;
            if (i == last_idx) last_cyc = cyc;
        end
        @(negedge e_rxc);
        gmii_rxdv = 1'b0;
        gmii_rxer = 1'b0;
        gmii_rxd  = 8'h00;
        repeat (12) @(negedge e_rxc);
    endtask

    // Expected RAM image: big-endian words of the kept bytes; a dropped frame loses its partial word.
    task automatic verify(input string tag, input bit accept, input int kept, input logic [15:0] tl, input logic [15:0] ul);
        logic [40:0] eq[$];
        logic [31:0] w;
        for (int i = 0; 4 * i < kept; i++) begin
            if (4 * i + 4 > kept && !accept) break;
            w = '0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < kept) w[31 - 8 * j -: 8] = pl[4 * i + j];
            if (i + 1 <= (1 << AW) - 1) eq.push_back({AW'(i + 1), w});
        end
        chk({tag, " nwrites"}, wq.size(), eq.size());
        foreach (eq[i])
            if (i < wq.size()) chk({tag, " write"}, wq[i], eq[i]);
        chk({tag, " done"}, n_done, accept);
        chk({tag, " drop"}, n_drop, !accept);
        if (accept) begin
            exp_tot = tl;
            exp_udp = ul;
        end
        chk({tag, " total_len"}, rx_total_length, exp_tot);
        chk({tag, " data_len"}, rx_data_length, exp_udp);
        if (accept && kept > 0) chk({tag, " latency"}, done_cyc - last_cyc, (kept % 4 == 0) ? 2 : 3);
        wq.delete();
        n_done = 0;
        n_drop = 0;
    endtask

    initial begin
        string s;
        int n, m, k, np;
        logic [47:0] dm;
        logic [31:0] di;
        logic [15:0] et, dp, ul, tl;
        logic [7:0] vi, pr;
        repeat (3) @(negedge e_rxc);
        chk("rst ram_we", ram_we, 0);
        chk("rst ram_addr", ram_addr, 1);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst total_len", rx_total_length, 48);
        chk("rst data_len", rx_data_length, 28);
        chk("rst done", frame_done, 0);
        chk("rst drop", frame_drop, 0);
        chk("rst state", rx_state, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge e_rxc);

        s = "HELLO ALINX AX516 \n\r";
        pl.delete();
        for (int i = 0; i < s.len(); i++) pl.push_back(s[i]);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd28, 16'd48, 7);
        send(frm.size(), -1, -1, pay_start + 19);
        if (wq.size() > 0) chk("hello word1", wq[0][31:0], 32'h48454C4C);
        verify("hello", 1, 20, 16'd48, 16'd28);

        pl.delete();
        for (int i = 1; i <= 5; i++) pl.push_back(8'(i));
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd13, 16'd33, 7);
        send(frm.size(), -1, -1, pay_start + 4);
        verify("unaligned", 1, 5, 16'd33, 16'd13);

        make_pl(20);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, 16'd8081, 16'd28, 16'd48, 7);
        send(frm.size(), -1, -1, -1);
        verify("bad_port", 0, 0, 16'd48, 16'd28);

        make_pl(20);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd28, 16'd48, 7);
        send(frm.size(), pay_start + 5, -1, -1);
        verify("rxer", 0, 5, 16'd48, 16'd28);

        make_pl(12);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd20, 16'd40, 6);
        send(frm.size(), -1, -1, pay_start + 11);
        verify("after_drop", 1, 12, 16'd40, 16'd20);

        pl.delete();
        build('1, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd8, 16'd28, 7);
        send(frm.size(), -1, -1, -1);
        verify("bcast", 1, 0, 16'd28, 16'd8);

        // The tail after the reset holds a complete preamble that must not restart parsing.
        make_pl(8);
        for (int i = 0; i < 7; i++) pl.push_back(8'h55);
        pl.push_back(8'hD5);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd24, 16'd44, 7);
        send(frm.size(), -1, 30, -1);
        chk("midrst state", st_after_rst, 0);
        chk("midrst nwrites", wq.size(), 0);
        chk("midrst done", n_done, 0);
        chk("midrst drop", n_drop, 0);
        chk("midrst total_len", rx_total_length, 48);
        chk("midrst data_len", rx_data_length, 28);
        chk("midrst ram_addr", ram_addr, 1);
        chk("midrst ram_wdata", ram_wdata, 0);
        exp_tot = 16'd48;
        exp_udp = 16'd28;
        make_pl(9);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd17, 16'd37, 7);
        send(frm.size(), -1, -1, pay_start + 8);
        verify("post_rst", 1, 9, 16'd37, 16'd17);

        for (int t = 0; t < 30; t++) begin
            k = $urandom_range(0, 11);
            n = $urandom_range(1, 40);
            make_pl(n);
            dm = MAC; et = 16'h0800; vi = 8'h45; pr = 8'h11; di = IP; dp = PORT;
            ul = 16'(n + 8); tl = 16'(n + 28); np = $urandom_range(6, 7);
            case (k)
                4:  dm = MAC ^ (48'd1 << $urandom_range(0, 47));
                5:  di = IP ^ (32'd1 << $urandom_range(0, 31));
                6:  et = 16'h0806;
                7:  pr = 8'h06;
                8:  vi = 8'h46;
                9:  tl = 16'(n + 27);
                10: np = 5;
                11: dp = PORT + 16'(1 + $urandom_range(0, 100));
                default: ;
            endcase
            build(dm, et, vi, pr, di, dp, ul, tl, np);
            if (k == 3) begin
                m = $urandom_range(0, n - 1);
                send(pay_start + m, -1, -1, -1);
                verify("rand_trunc", 0, m, tl, ul);
            end else if (k < 3) begin
                send(frm.size(), -1, -1, pay_start + n - 1);
                verify("rand_ok", 1, n, tl, ul);
            end else begin
                send(frm.size(), -1, -1, -1);
                verify("rand_bad", 0, 0, tl, ul);
            end
        end

        make_pl(2060);
        build(MAC, 16'h0800, 8'h45, 8'h11, IP, PORT, 16'd2068, 16'd2088, 7);
        send(frm.size(), -1, -1, pay_start + 2059);
        verify("saturate", 1, 2060, 16'd2088, 16'd2068);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_rx_parser.md
Name: udp_rx_parser

Overview:
- GMII receive-side parser for the Ethernet/UDP path, clocked by e_rxc.
- Validates preamble/SFD, Ethernet, IPv4 and UDP headers against the local addresses.
- Packs UDP payload bytes into 32-bit words and writes them to the shared payload RAM, so the transmit side echoes them.
- Publishes the committed IP total length and UDP length, plus a one-cycle frame-accepted pulse that drives transmit length selection.

Parameters:
- LOCAL_MAC, 48'h000A35010203, accepted destination MAC; 48'hFFFFFFFFFFFF is always accepted.
- LOCAL_IP, 32'hC0A80002, accepted destination IPv4 address.
- LOCAL_PORT, 16'd8080, accepted UDP destination port.
- ADDR_W, 9, payload RAM address width.

Ports:
- e_rxc  input  1  GMII receive clock (125 MHz); all logic on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- gmii_rxdv  input  1  GMII receive data valid.
- gmii_rxer  input  1  GMII receive error.
- gmii_rxd  input  8  GMII receive byte.
- ram_we  output  1  payload RAM write enable.
- ram_addr  output  ADDR_W  payload RAM write address.
- ram_wdata  output  32  payload word; first byte in [31:24].
- rx_total_length  output  16  IP total length of the last accepted frame.
- rx_data_length  output  16  UDP length field of the last accepted frame, including the 8-byte header.
- frame_done  output  1  one-cycle pulse: frame accepted, all payload written.
- frame_drop  output  1  one-cycle pulse: frame rejected.
- rx_state  output  4  current state encoding, for debug.

Behaviour:
- Reset values:
  - ram_we=0, ram_addr=1, ram_wdata=0.
  - rx_total_length=16'd48, rx_data_length=16'd28 (the default 20-byte payload frame).
  - frame_done=0, frame_drop=0, state=IDLE.
- Reset mid-frame returns to IDLE next edge. The rest of that frame is ignored until gmii_rxdv is low for at least one cycle.
- States and encodings:
  - IDLE (0): wait for rxdv=1 with rxd=0x55 → PREAMBLE.
  - PREAMBLE (1): 0x55 bytes continue. 0xD5 after 6-7 total 0x55 bytes → ETH_HDR. Any other byte, or a wrong 0x55 count → DROP.
  - ETH_HDR (2), 14 bytes:
    - bytes 0-5 must equal LOCAL_MAC or broadcast;
    - bytes 12-13 must equal 16'h0800;
    - otherwise DROP → IP_HDR.
  - IP_HDR (3), 20 bytes:
    - byte 0 must be 8'h45;
    - bytes 2-3 are captured into a shadow total length;
    - byte 9 must be 8'h11;
    - bytes 16-19 must equal LOCAL_IP;
    - otherwise DROP → UDP_HDR.
  - UDP_HDR (4), 8 bytes:
    - bytes 2-3 must equal LOCAL_PORT;
    - bytes 4-5 are captured into a shadow UDP length;
    - DROP if UDP length <8 or >(shadow total − 20).
    - Length 8 goes directly to COMMIT; otherwise → PAYLOAD.
  - PAYLOAD (5): accept exactly (UDP length − 8) bytes, big-endian packing.
    - Each 4th byte: ram_we=1 for one cycle, on the cycle after that byte is sampled.
    - ram_addr post-increments after each write.
    - After the last byte, any partial word is zero-padded in its low bytes and written one cycle later.
    - Then → COMMIT.
  - COMMIT (6): shadow lengths are copied to rx_total_length and rx_data_length; frame_done=1 for this cycle → WAIT_END.
  - DROP (7): frame_drop=1 for one cycle → WAIT_END.
  - WAIT_END (8): ignore bytes (Ethernet pad and FCS included) until rxdv=0 → IDLE; ram_addr reloads to 1.
- Abort rules:
  - gmii_rxer=1 with rxdv=1 in any header or PAYLOAD state → DROP.
  - rxdv falling before the payload byte count completes → DROP.
  - An in-progress partial word is not written on drop.
- Drop side effects:
  - RAM words already written for a dropped frame stay in RAM.
  - rx_total_length and rx_data_length change only in COMMIT.
- Address limit: ram_addr saturates at 2^ADDR_W−1. Words beyond the limit are discarded, but byte counting continues and the frame still commits.
- FCS is not checked.
- Latency: frame_done is 2 cycles after the last payload byte for an aligned length, 3 cycles for an unaligned one.

Test Plan:
- Valid frame, UDP length 28, 20 payload bytes "HELLO ALINX AX516\n\r":
  - 5 writes to addr 1..5; word 1 = 32'h48454C4C;
  - frame_done once; rx_total_length=48, rx_data_length=28.
- Unaligned payload, UDP length 13 (5 bytes 01..05):
  - writes 32'h01020304 @1 and 32'h05000000 @2;
  - lengths 33/13.
- Wrong destination port 8081: frame_drop pulse, no ram_we, lengths remain 48/28.
- gmii_rxer asserted at payload byte 6 of a 20-byte payload:
  - one word written @1, frame_drop, no frame_done;
  - next valid frame writes starting @1.
- Broadcast MAC, zero payload (UDP length 8): frame_done, no writes, lengths 28/8.
- reset_n low for one cycle mid-IP header:
  - all outputs return to reset values;
  - the remaining bytes are ignored;
  - a following valid frame is accepted.
